// File: rtl/mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter
//
// Shares one downstream memory/cache port between the instruction-fetch
// requester (i_*) and the load-store-queue requester (d_*). Each side keeps at
// most one request outstanding and holds it until its completion pulse.
//
// A four-state FSM (IDLE -> SERVE_I / SERVE_D -> RECOVER -> IDLE) picks one
// requester, latches its command into the downstream registers at the grant
// edge, and holds that command until mem_resp. The response is steered
// combinationally back to the granted side. RECOVER is one dead cycle that
// gives the requester time to drop its request before the next grant.
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   i_read/i_address  fetch read request (held until i_resp)
//   i_rdata/i_resp    fetch completion pulse and read data
//   d_read/d_write    LSQ read / write request (held until d_resp)
//   d_byte_enable, d_address, d_wdata   LSQ command fields
//   d_rdata/d_resp    LSQ completion pulse and read data
//   mem_read/mem_write/mem_byte_enable/mem_address/mem_wdata
//                     registered downstream command
//   mem_rdata/mem_resp downstream read data and one-cycle completion pulse
//
// Parameters:
//   width       data/address width; byte-enable width is width/8
//   d_priority  0: round-robin on simultaneous requests, 1: LSQ always wins
// -----------------------------------------------------------------------------
module mem_port_arbiter #(
    parameter int width      = 32,
    parameter int d_priority = 0
) (
    input  logic                 clk,
    input  logic                 rst,

    input  logic                 i_read,
    input  logic [width-1:0]     i_address,
    output logic [width-1:0]     i_rdata,
    output logic                 i_resp,

    input  logic                 d_read,
    input  logic                 d_write,
    input  logic [width/8-1:0]   d_byte_enable,
    input  logic [width-1:0]     d_address,
    input  logic [width-1:0]     d_wdata,
    output logic [width-1:0]     d_rdata,
    output logic                 d_resp,

    output logic                 mem_read,
    output logic                 mem_write,
    output logic [width/8-1:0]   mem_byte_enable,
    output logic [width-1:0]     mem_address,
    output logic [width-1:0]     mem_wdata,
    input  logic [width-1:0]     mem_rdata,
    input  logic                 mem_resp
);

    localparam int be_width = width / 8;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SERVE_I = 2'd1,
        SERVE_D = 2'd2,
        RECOVER = 2'd3
    } state_t;

    // last_grant: 0 = fetch side, 1 = LSQ side
    state_t                 state_reg,       state_next;
    logic                   last_grant_reg,  last_grant_next;
    logic                   cmd_read_reg,    cmd_read_next;
    logic                   cmd_write_reg,   cmd_write_next;
    logic [be_width-1:0]    cmd_be_reg,      cmd_be_next;
    logic [width-1:0]       cmd_address_reg, cmd_address_next;
    logic [width-1:0]       cmd_wdata_reg,   cmd_wdata_next;

    logic req_i;
    logic req_d;
    logic grant_i;
    logic grant_d;

    assign req_i = i_read;
    assign req_d = d_read | d_write;

    // On a tie the LSQ wins if it has fixed priority, or if fetch was the
    // last side served (round-robin).
    assign grant_d = req_d && (!req_i || (d_priority != 0) || !last_grant_reg);
    assign grant_i = req_i && !grant_d;

    // -------------------------------------------------------------------------
    // State register (plus the latched downstream command)
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg       <= IDLE;
            last_grant_reg  <= 1'b1;
            cmd_read_reg    <= 1'b0;
            cmd_write_reg   <= 1'b0;
            cmd_be_reg      <= '0;
            cmd_address_reg <= '0;
            cmd_wdata_reg   <= '0;
        end else begin
            state_reg       <= state_next;
            last_grant_reg  <= last_grant_next;
            cmd_read_reg    <= cmd_read_next;
            cmd_write_reg   <= cmd_write_next;
            cmd_be_reg      <= cmd_be_next;
            cmd_address_reg <= cmd_address_next;
            cmd_wdata_reg   <= cmd_wdata_next;
        end
    end

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_next       = state_reg;
        last_grant_next  = last_grant_reg;
        cmd_read_next    = cmd_read_reg;
        cmd_write_next   = cmd_write_reg;
        cmd_be_next      = cmd_be_reg;
        cmd_address_next = cmd_address_reg;
        cmd_wdata_next   = cmd_wdata_reg;

        case (state_reg)
            IDLE: begin
                if (grant_i) begin
                    state_next       = SERVE_I;
                    last_grant_next  = 1'b0;
                    cmd_read_next    = 1'b1;
                    cmd_write_next   = 1'b0;
                    cmd_be_next      = '1;
                    cmd_address_next = i_address;
                    cmd_wdata_next   = '0;
                end else if (grant_d) begin
                    state_next       = SERVE_D;
                    last_grant_next  = 1'b1;
                    // A simultaneous read+write is treated as a write.
                    cmd_read_next    = d_read & ~d_write;
                    cmd_write_next   = d_write;
                    cmd_be_next      = d_byte_enable;
                    cmd_address_next = d_address;
                    cmd_wdata_next   = d_wdata;
                end
            end

            SERVE_I, SERVE_D: begin
                // The command is held (no timeout) until memory completes,
                // even if the requester has withdrawn.
                if (mem_resp) begin
                    state_next       = RECOVER;
                    cmd_read_next    = 1'b0;
                    cmd_write_next   = 1'b0;
                    cmd_be_next      = '0;
                    cmd_address_next = '0;
                    cmd_wdata_next   = '0;
                end
            end

            default: begin // RECOVER
                state_next       = IDLE;
                cmd_read_next    = 1'b0;
                cmd_write_next   = 1'b0;
                cmd_be_next      = '0;
                cmd_address_next = '0;
                cmd_wdata_next   = '0;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Output logic
    // -------------------------------------------------------------------------
    always_comb begin
        i_resp = 1'b0;
        d_resp = 1'b0;
        // A requester that dropped its request (e.g. flushed fetch) gets no
        // completion pulse; mem_resp outside SERVE_* is ignored.
        case (state_reg)
            SERVE_I: i_resp = mem_resp & req_i;
            SERVE_D: d_resp = mem_resp & req_d;
            default: ;
        endcase
    end

    // Read data is forced to zero whenever its completion pulse is low.
    for (genvar gi = 0; gi < width; gi++) begin : g_rdata_mask
        assign i_rdata[gi] = mem_rdata[gi] & i_resp;
        assign d_rdata[gi] = mem_rdata[gi] & d_resp;
    end

    assign mem_read        = cmd_read_reg;
    assign mem_write       = cmd_write_reg;
    assign mem_byte_enable = cmd_be_reg;
    assign mem_address     = cmd_address_reg;
    assign mem_wdata       = cmd_wdata_reg;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_port_arbiter
//
// Directed testbench for mem_port_arbiter. Two instances share all inputs:
// dut_rr (round-robin) carries most checks; dut_dp (LSQ fixed priority) is
// only checked in the contention scenario after a common reset.
// Inputs change 1 time unit after the rising edge; outputs are sampled there
// (registered) or 1 unit later (combinational response paths).
// -----------------------------------------------------------------------------
module tb_mem_port_arbiter;

    localparam int W  = 32;
    localparam int BW = W / 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic           rst;
    logic           i_read;
    logic [W-1:0]   i_address;
    logic           d_read;
    logic           d_write;
    logic [BW-1:0]  d_byte_enable;
    logic [W-1:0]   d_address;
    logic [W-1:0]   d_wdata;
    logic [W-1:0]   mem_rdata;
    logic           mem_resp;

    logic [W-1:0]   a_i_rdata, a_d_rdata, a_mem_address, a_mem_wdata;
    logic           a_i_resp, a_d_resp, a_mem_read, a_mem_write;
    logic [BW-1:0]  a_mem_be;

    logic [W-1:0]   b_i_rdata, b_d_rdata, b_mem_address, b_mem_wdata;
    logic           b_i_resp, b_d_resp, b_mem_read, b_mem_write;
    logic [BW-1:0]  b_mem_be;

    mem_port_arbiter #(.width(W), .d_priority(0)) dut_rr (
        .clk(clk), .rst(rst),
        .i_read(i_read), .i_address(i_address),
        .i_rdata(a_i_rdata), .i_resp(a_i_resp),
        .d_read(d_read), .d_write(d_write), .d_byte_enable(d_byte_enable),
        .d_address(d_address), .d_wdata(d_wdata),
        .d_rdata(a_d_rdata), .d_resp(a_d_resp),
        .mem_read(a_mem_read), .mem_write(a_mem_write),
        .mem_byte_enable(a_mem_be), .mem_address(a_mem_address),
        .mem_wdata(a_mem_wdata), .mem_rdata(mem_rdata), .mem_resp(mem_resp)
    );

    mem_port_arbiter #(.width(W), .d_priority(1)) dut_dp (
        .clk(clk), .rst(rst),
        .i_read(i_read), .i_address(i_address),
        .i_rdata(b_i_rdata), .i_resp(b_i_resp),
        .d_read(d_read), .d_write(d_write), .d_byte_enable(d_byte_enable),
        .d_address(d_address), .d_wdata(d_wdata),
        .d_rdata(b_d_rdata), .d_resp(b_d_resp),
        .mem_read(b_mem_read), .mem_write(b_mem_write),
        .mem_byte_enable(b_mem_be), .mem_address(b_mem_address),
        .mem_wdata(b_mem_wdata), .mem_rdata(mem_rdata), .mem_resp(mem_resp)
    );

    int tests_run    = 0;
    int tests_failed = 0;

    task automatic check_eq(input string tag, input logic [W-1:0] obs,
                            input logic [W-1:0] exp);
        tests_run++;
        if (obs !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; i_read = 1'b0; i_address = '0;
        d_read = 1'b0; d_write = 1'b0; d_byte_enable = '0;
        d_address = '0; d_wdata = '0; mem_rdata = '0; mem_resp = 1'b0;
        tick();
        tick();

        // ---------------- reset state ----------------
        check_eq("rst_mem_read",  {31'd0, a_mem_read},  32'd0);
        check_eq("rst_mem_write", {31'd0, a_mem_write}, 32'd0);
        check_eq("rst_mem_addr",  a_mem_address,        32'd0);
        check_eq("rst_i_resp",    {31'd0, a_i_resp},    32'd0);
        check_eq("rst_d_resp",    {31'd0, a_d_resp},    32'd0);
        $display("[TB] txn reset");
        rst = 1'b0;

        // ---------------- fetch only ----------------
        i_read = 1'b1; i_address = 32'h60;
        tick();                                   // cycle 1
        check_eq("f_mem_read",  {31'd0, a_mem_read},  32'd1);
        check_eq("f_mem_write", {31'd0, a_mem_write}, 32'd0);
        check_eq("f_mem_addr",  a_mem_address,        32'h60);
        check_eq("f_mem_be",    {28'd0, a_mem_be},    32'hF);
        check_eq("f_i_resp_early", {31'd0, a_i_resp}, 32'd0);
        tick(); tick(); tick();                   // cycle 4
        mem_resp = 1'b1; mem_rdata = 32'h00500093;
        #1;
        check_eq("f_i_resp",  {31'd0, a_i_resp}, 32'd1);
        check_eq("f_i_rdata", a_i_rdata,         32'h00500093);
        check_eq("f_d_resp",  {31'd0, a_d_resp}, 32'd0);
        check_eq("f_d_rdata", a_d_rdata,         32'd0);
        tick();                                   // cycle 5, RECOVER
        mem_resp = 1'b0; i_read = 1'b0;
        #1;
        check_eq("f_mem_read_drop", {31'd0, a_mem_read}, 32'd0);
        check_eq("f_i_rdata_zero",  a_i_rdata,           32'd0);
        tick();                                   // IDLE
        $display("[TB] txn fetch-only read 0x60");

        // ---------------- LSQ store ----------------
        d_write = 1'b1; d_address = 32'h100; d_wdata = 32'hDEADBEEF;
        d_byte_enable = 4'h3;
        tick();
        check_eq("s_mem_write", {31'd0, a_mem_write}, 32'd1);
        check_eq("s_mem_read",  {31'd0, a_mem_read},  32'd0);
        check_eq("s_mem_addr",  a_mem_address,        32'h100);
        check_eq("s_mem_wdata", a_mem_wdata,          32'hDEADBEEF);
        check_eq("s_mem_be",    {28'd0, a_mem_be},    32'h3);
        tick();
        mem_resp = 1'b1; mem_rdata = 32'h12345678;
        #1;
        check_eq("s_d_resp",  {31'd0, a_d_resp}, 32'd1);
        check_eq("s_d_rdata", a_d_rdata,         32'h12345678);
        check_eq("s_i_resp",  {31'd0, a_i_resp}, 32'd0);
        tick();
        mem_resp = 1'b0; d_write = 1'b0;
        #1;
        check_eq("s_mem_write_drop", {31'd0, a_mem_write}, 32'd0);
        tick();
        $display("[TB] txn LSQ store 0x100");

        // ---------------- spurious mem_resp in IDLE ----------------
        mem_resp = 1'b1; mem_rdata = 32'hCAFEF00D;
        #1;
        check_eq("sp_i_resp", {31'd0, a_i_resp}, 32'd0);
        check_eq("sp_d_resp", {31'd0, a_d_resp}, 32'd0);
        tick();
        mem_resp = 1'b0;
        check_eq("sp_mem_read", {31'd0, a_mem_read}, 32'd0);
        i_read = 1'b1; i_address = 32'h44;
        tick();                                   // still grants: was IDLE
        check_eq("sp_grant_read", {31'd0, a_mem_read}, 32'd1);
        check_eq("sp_grant_addr", a_mem_address,       32'h44);
        mem_resp = 1'b1;
        tick();
        mem_resp = 1'b0; i_read = 1'b0;
        tick();
        $display("[TB] txn spurious resp then fetch 0x44");

        // ---------------- illegal d_read & d_write ----------------
        d_read = 1'b1; d_write = 1'b1; d_address = 32'h200; d_byte_enable = 4'hF;
        tick();
        check_eq("il_mem_write", {31'd0, a_mem_write}, 32'd1);
        check_eq("il_mem_read",  {31'd0, a_mem_read},  32'd0);
        mem_resp = 1'b1;
        tick();
        mem_resp = 1'b0; d_read = 1'b0; d_write = 1'b0;
        tick();
        $display("[TB] txn illegal rd+wr 0x200");

        // ---------------- withdrawn fetch ----------------
        i_read = 1'b1; i_address = 32'h80;
        tick();
        check_eq("w_mem_read", {31'd0, a_mem_read}, 32'd1);
        i_read = 1'b0;
        tick();
        check_eq("w_mem_read_held", {31'd0, a_mem_read}, 32'd1);
        check_eq("w_mem_addr_held", a_mem_address,       32'h80);
        mem_resp = 1'b1; mem_rdata = 32'hAAAA5555;
        #1;
        check_eq("w_i_resp",  {31'd0, a_i_resp}, 32'd0);
        check_eq("w_i_rdata", a_i_rdata,         32'd0);
        tick();
        mem_resp = 1'b0;
        check_eq("w_recover_read", {31'd0, a_mem_read}, 32'd0);
        tick();
        $display("[TB] txn withdrawn fetch 0x80");

        // ---------------- reset during SERVE_D ----------------
        d_read = 1'b1; d_address = 32'h300;
        tick();
        check_eq("r_serve_d_read", {31'd0, a_mem_read}, 32'd1);
        check_eq("r_serve_d_addr", a_mem_address,       32'h300);
        i_read = 1'b1; i_address = 32'h60;
        rst = 1'b1;
        tick();
        check_eq("r_mem_read",  {31'd0, a_mem_read},  32'd0);
        check_eq("r_mem_addr",  a_mem_address,        32'd0);
        check_eq("r_mem_be",    {28'd0, a_mem_be},    32'd0);
        rst = 1'b0;
        tick();                                   // both pending: fetch first
        check_eq("r_first_read", {31'd0, a_mem_read}, 32'd1);
        check_eq("r_first_addr", a_mem_address,       32'h60);
        mem_resp = 1'b1;
        tick();
        mem_resp = 1'b0; i_read = 1'b0; d_read = 1'b0;
        tick();
        tick();
        $display("[TB] txn reset during LSQ serve");

        // ---------------- contention ----------------
        rst = 1'b1;
        i_read = 1'b1; i_address = 32'h60;
        d_write = 1'b1; d_address = 32'h100; d_wdata = 32'h0BADF00D;
        d_byte_enable = 4'hF;
        tick();
        rst = 1'b0;
        tick();                                   // first grant edge
        for (int r = 0; r < 4; r++) begin
            logic exp_i;
            exp_i = (r % 2 == 0);
            check_eq($sformatf("c_rr_read_%0d", r),  {31'd0, a_mem_read},  {31'd0, exp_i});
            check_eq($sformatf("c_rr_write_%0d", r), {31'd0, a_mem_write}, {31'd0, ~exp_i});
            check_eq($sformatf("c_dp_write_%0d", r), {31'd0, b_mem_write}, 32'd1);
            mem_resp = 1'b1;
            #1;
            check_eq($sformatf("c_rr_iresp_%0d", r), {31'd0, a_i_resp}, {31'd0, exp_i});
            check_eq($sformatf("c_rr_dresp_%0d", r), {31'd0, a_d_resp}, {31'd0, ~exp_i});
            check_eq($sformatf("c_dp_dresp_%0d", r), {31'd0, b_d_resp}, 32'd1);
            check_eq($sformatf("c_dp_iresp_%0d", r), {31'd0, b_i_resp}, 32'd0);
            tick();                               // RECOVER
            mem_resp = 1'b0;
            check_eq($sformatf("c_recover_%0d", r), {31'd0, a_mem_read | a_mem_write}, 32'd0);
            tick();                               // IDLE
            tick();                               // next grant
            $display("[TB] txn contention round %0d: rr grant %s, dp grant D",
                     r, exp_i ? "I" : "D");
        end
        i_read = 1'b0; d_write = 1'b0;

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
